// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, field positions and helpers for the data-cache controller
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_FILL
    } state_e;

    localparam int TAG_HI    = 31;
    localparam int TAG_LO    = 9;
    localparam int IDX_HI    = 8;
    localparam int IDX_LO    = 5;
    localparam int WORD_HI   = 4;
    localparam int WORD_LO   = 2;
    localparam int TAG_W     = TAG_HI - TAG_LO + 1;
    localparam int IDX_W     = IDX_HI - IDX_LO + 1;
    localparam int WORD_W    = WORD_HI - WORD_LO + 1;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;
    localparam int STAG_W    = 25;
    localparam int LINE_W    = 256;

    function automatic logic [STAG_W-1:0] make_tag(input logic dirty, input logic [TAG_W-1:0] tag);
        return {1'b1, dirty, tag};
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx);
        return {tag, idx, 5'b0};
    endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// rtl/dcache_line_merge.sv - word extract and word insert on a 256-bit cache line
module dcache_line_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WORD_W-1:0] word_sel_i,
    input  logic [31:0]       word_i,
    output logic [31:0]       word_o,
    output logic [LINE_W-1:0] line_o
);

    logic [7:0] bit_off;

    assign bit_off = {word_sel_i, 5'b0};
    assign word_o  = line_i[bit_off +: 32];

    always_comb begin
        line_o                = line_i;
        line_o[bit_off +: 32] = word_i;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - 2-way data-cache controller: hit service, write-back and refill sequencing
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int MEM_LAT_MAX = 1023
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_write_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    output logic                sram_enable_o,
    output logic                sram_write_o,
    output logic [IDX_W-1:0]    sram_addr_o,
    output logic [STAG_W-1:0]   sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    input  logic [STAG_W-1:0]   sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic                sram_hit_i,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [31:0]         mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i,
    output logic                err_o
);

    // err_o is registered, so the trip point is one count early to land in the MEM_LAT_MAX-th wait cycle
    localparam logic [31:0] WD_TRIP = 32'(MEM_LAT_MAX - 1);

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    cpu_tag_q, cpu_tag_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LINE_W-1:0]   victim_data_q, victim_data_d;
    logic [LINE_W-1:0]   fill_line_q, fill_line_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         wd_cnt_q, wd_cnt_d;
    logic                err_q, err_d;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WORD_W-1:0]   req_word;
    logic [31:0]         hit_word;
    logic [LINE_W-1:0]   merged_line;
    logic                in_idle;
    logic                waiting;
    logic                unused_byte_bits;

    assign req_tag          = cpu_addr_i[TAG_HI:TAG_LO];
    assign req_idx          = cpu_addr_i[IDX_HI:IDX_LO];
    assign req_word         = cpu_addr_i[WORD_HI:WORD_LO];
    assign unused_byte_bits = ^cpu_addr_i[1:0];
    assign in_idle          = (state_q == S_IDLE);
    assign waiting          = (state_q == S_WRITEBACK) || (state_q == S_REFILL);

    dcache_line_merge u_merge (
        .line_i     (sram_data_i),
        .word_sel_i (req_word),
        .word_i     (cpu_data_i),
        .word_o     (hit_word),
        .line_o     (merged_line)
    );

    always_comb begin
        state_d       = state_q;
        cpu_tag_d     = cpu_tag_q;
        idx_d         = idx_q;
        victim_data_d = victim_data_q;
        fill_line_d   = fill_line_q;
        mem_en_d      = mem_en_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        wd_cnt_d      = wd_cnt_q;
        err_d         = err_q;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        cpu_data_o    = '0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    sram_enable_o = 1'b1;
                    sram_addr_o   = req_idx;
                    sram_tag_o    = make_tag(1'b0, req_tag);
                    if (sram_hit_i) begin
                        if (cpu_write_i) begin
                            sram_write_o = 1'b1;
                            sram_tag_o   = make_tag(1'b1, req_tag);
                            sram_data_o  = merged_line;
                        end else begin
                            cpu_data_o = hit_word;
                        end
                    end else begin
                        cpu_tag_d     = req_tag;
                        idx_d         = req_idx;
                        victim_data_d = sram_data_i;
                        mem_en_d      = 1'b1;
                        wd_cnt_d      = '0;
                        if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
                            state_d    = S_WRITEBACK;
                            mem_we_d   = 1'b1;
                            mem_addr_d = line_addr(sram_tag_i[TAG_W-1:0], req_idx);
                        end else begin
                            state_d    = S_REFILL;
                            mem_we_d   = 1'b0;
                            mem_addr_d = line_addr(req_tag, req_idx);
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d    = S_REFILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr(cpu_tag_q, idx_q);
                    wd_cnt_d   = '0;
                end
            end
            S_REFILL: begin
                if (mem_ack_i) begin
                    state_d     = S_FILL;
                    fill_line_d = mem_data_i;
                    mem_en_d    = 1'b0;
                end
            end
            S_FILL: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_addr_o   = idx_q;
                sram_tag_o    = make_tag(1'b0, cpu_tag_q);
                sram_data_o   = fill_line_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (waiting && !mem_ack_i) begin
            if (wd_cnt_q != '1) begin
                wd_cnt_d = wd_cnt_q + 32'd1;
            end
            if (wd_cnt_d >= WD_TRIP) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cpu_tag_q     <= '0;
            idx_q         <= '0;
            victim_data_q <= '0;
            fill_line_q   <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            wd_cnt_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_tag_q     <= cpu_tag_d;
            idx_q         <= idx_d;
            victim_data_q <= victim_data_d;
            fill_line_q   <= fill_line_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            wd_cnt_q      <= wd_cnt_d;
            err_q         <= err_d;
        end
    end

    assign cpu_stall_o  = (in_idle && cpu_req_i && !sram_hit_i) || !in_idle;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = victim_data_q;
    assign err_o        = err_q;

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Data-cache controller. It sits between the CPU memory stage, the 2-way, 16-set data-cache SRAM and the off-chip data memory. It decodes CPU word accesses into set/tag lookups and services hits without stalling. On a miss it runs the write-back and refill sequence against memory through an enable/ack handshake. It drives the SRAM's lookup/write port as the initiator and consumes its tag/data/hit responses.

## Interface
Parameters:
- MEM_LAT_MAX, 1023, watchdog bound in cycles for mem_ack_i; exceeding it sets err_o (sticky until reset).

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- cpu_req_i  in  1  access request, held until cpu_stall_o low
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address; [31:9] tag, [8:5] set index, [4:2] word, [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i & !cpu_stall_o
- cpu_stall_o  out  1  stall pipeline
- sram_enable_o / sram_write_o  out  1 / 1  SRAM lookup / write strobe
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_tag_i / sram_data_i / sram_hit_i  in  25 / 256 / 1  SRAM hit-way or LRU-victim response (combinational)
- mem_enable_o / mem_write_o  out  1 / 1  memory request / direction
- mem_addr_o  out  32  line address, [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line, valid on mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse
- err_o  out  1  memory watchdog expired

## Operation
- States: IDLE, WRITEBACK, REFILL, FILL.
- IDLE: sram_enable_o = cpu_req_i; sram_addr_o = addr[8:5]; sram_tag_o = {1, 0, addr[31:9]}.
  - Load hit: cpu_data_o = sram_data_i word addr[4:2].
  - Store hit: sram_write_o = 1, sram_data_o = sram_data_i with word addr[4:2] replaced by cpu_data_i, sram_tag_o = {1, 1, tag}.
  - Miss: latch victim tag/data, index and CPU tag. Victim valid & dirty -> WRITEBACK; otherwise -> REFILL.
- WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = latched victim line. On ack -> REFILL.
- REFILL: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu tag, index, 5'b0}. On ack, capture mem_data_i -> FILL.
- FILL: sram_enable_o = 1, sram_write_o = 1, sram_data_o = captured line, sram_tag_o = {1, 0, cpu tag} -> IDLE. The SRAM replaces the LRU way.
- Back in IDLE the original access re-looks-up and hits; stores then merge as a normal hit.
- cpu_stall_o = (IDLE & cpu_req_i & !sram_hit_i) | state != IDLE.
- Watchdog: counter clears on each memory request start and counts while waiting. Reaching MEM_LAT_MAX sets err_o; the FSM keeps waiting.

## Timing
- Reset values: state IDLE; all outputs 0, including cpu_stall_o, mem_enable_o and err_o; latches cleared.
- Hit: zero added latency; data is combinational in the request cycle.
- Clean miss: 1 (detect) + N (memory wait, ack cycle included) + 1 (FILL) + 1 (hit) cycles.
- Dirty miss: adds the write-back wait.
- mem_enable_o and mem_addr_o are registered and held stable until the ack cycle. They drop the cycle after ack, except on the WRITEBACK->REFILL transition, where enable stays high with mem_write_o = 0 and the new address.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- cpu_req_i falling during a miss: the sequence completes anyway.
- rst_i in any state: IDLE at the next edge; any outstanding memory transaction is abandoned.

## Structure
- dcache_pkg: state enum, field positions (TAG 31:9, IDX 8:5, WORD 4:2), valid/dirty bit indices 24/23, line width 256.
- Sub-module dcache_line_merge: combinational word extract (256->32) and word insert (256+32->256). It is shared by the hit-load and hit-store paths.

## Test plan
- Reset, then load 0x0000_0120 with an empty cache -> REFILL with mem_addr_o 0x120. Ack with line word0 = 0xDEAD_BEEF -> FILL, then cpu_data_o = 0xDEAD_BEEF with stall low.
- Store 0x5A5A_5A5A to 0x124 after the above -> no stall; SRAM write of word1, sram_tag_o = {1, 1, 0}.
- Load 0x320, then 0x520 (same set 9, tags 1 and 2) after the dirty 0x120 line -> 0x320 refills the free way. 0x520 evicts LRU line 0x120: WRITEBACK at addr 0x120 with word1 = 0x5A5A_5A5A, then REFILL at 0x520.
- Memory ack delayed 50 cycles -> stall held for the whole wait; mem_addr_o stable; err_o stays 0.
- rst_i asserted in the second REFILL wait cycle -> next cycle IDLE, mem_enable_o 0, cpu_stall_o 0.
- MEM_LAT_MAX = 8, no ack -> err_o rises in the 8th wait cycle and stays high until rst_i.
